// File: rtl/sa_result_drain.sv
// Snapshots all ROWS column results once every column is valid, then streams them out column 0..ROWS-1.
// Latency: the edge that sees all valids also captures the snapshot; column 0 is presented in the next cycle; one beat per cycle.
// Backpressure: m_data/m_last are held while m_valid && !m_ready; rread pulses once after the last beat. Define SA_DRAIN_RELU_EN to clamp negative results to 0 at capture.
module sa_result_drain #(
    parameter int ROWS     = 8,
    parameter int OUTWIDTH = 32,
    parameter int CNTW     = 16
)(
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [ROWS-1:0][OUTWIDTH-1:0]  r_in,
    input  logic [ROWS-1:0]                rvalid_in,
    output logic                           rread,
    output logic [OUTWIDTH-1:0]            m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_last,
    output logic [CNTW-1:0]                tile_cnt,
    output logic                           busy
);

    localparam int              IDXW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [IDXW-1:0]               idx;
    logic [ROWS-1:0][OUTWIDTH-1:0] snap;
    logic [ROWS-1:0][OUTWIDTH-1:0] snap_cap;
    logic                          all_vld;
    logic                          beat_acc;
    logic                          last_acc;

    assign all_vld  = &rvalid_in;
    assign beat_acc = (state == S_SEND) && m_ready;
    assign last_acc = beat_acc && (idx == LAST_IDX);

    // Value written into the snapshot: optionally clamped so the stream never carries a negative result.
    always_comb begin
        snap_cap = r_in;
`ifdef SA_DRAIN_RELU_EN
        for (int i = 0; i < ROWS; i++) begin
            if (r_in[i][OUTWIDTH-1]) begin
                snap_cap[i] = '0;
            end
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: wait for a full set of valids, drain, acknowledge, then give the core one cycle to drop stale valids.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (all_vld)  state_nxt = S_SEND;
            S_SEND:    if (last_acc) state_nxt = S_ACK;
            S_ACK:                   state_nxt = S_RELEASE;
            S_RELEASE:               state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // Snapshot, column index and drained-tile counter; inputs are only looked at in IDLE so later changes cannot leak into a tile.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            snap     <= '0;
            idx      <= '0;
            tile_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (all_vld) begin
                        snap <= snap_cap;
                        idx  <= '0;
                    end
                end
                S_SEND: begin
                    if (beat_acc && !last_acc) begin
                        idx <= idx + IDXW'(1);
                    end
                end
                S_ACK: begin
                    tile_cnt <= tile_cnt + CNTW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode from state; data is zero outside SEND so nothing stale is ever presented.
    always_comb begin
        m_valid = (state == S_SEND);
        m_data  = m_valid ? snap[idx] : '0;
        m_last  = m_valid && (idx == LAST_IDX);
        rread   = (state == S_ACK);
        busy    = (state != S_IDLE);
    end

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: reset, partial valids, a table of drained tiles, mid-tile reset.
// Expected values are hand-derived per tile; outputs are sampled on the falling edge.
// Stream backpressure is driven from a per-tile ready pattern.
module tb_sa_result_drain;

    localparam int ROWS = 8;
    localparam int OW   = 32;
    localparam int CW   = 2;

    logic                     clk;
    logic                     rstn;
    logic [ROWS-1:0][OW-1:0]  r_in;
    logic [ROWS-1:0]          rvalid_in;
    logic                     rread;
    logic [OW-1:0]            m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_last;
    logic [CW-1:0]            tile_cnt;
    logic                     busy;

    sa_result_drain #(.ROWS(ROWS), .OUTWIDTH(OW), .CNTW(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .r_in      (r_in),
        .rvalid_in (rvalid_in),
        .rread     (rread),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .tile_cnt  (tile_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string                   name;
        logic [ROWS-1:0][OW-1:0] vals;
        logic [ROWS-1:0][OW-1:0] expv;
        logic [15:0]             rpat;
        logic [CW-1:0]           exp_cnt;
        bit                      change_mid;
    } vec_t;

    vec_t tbl [5];
    int   n_chk;
    int   n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_tile(input vec_t v);
        int beat;
        int cyc;
        beat = 0;
        cyc  = 0;
        r_in      = v.vals;
        rvalid_in = '1;
        m_ready   = 1'b0;
        @(negedge clk);
        while (beat < ROWS && cyc < 200) begin
            if (cyc == 0) rvalid_in = '0;
            if (v.change_mid && cyc == 2) begin
                r_in      = ~v.vals;
                rvalid_in = '1;
            end
            m_ready = v.rpat[cyc % 16];
            chk({v.name, " m_valid"}, 32'(m_valid), 32'd1);
            chk({v.name, " m_data"},  m_data, v.expv[beat]);
            chk({v.name, " m_last"},  32'(m_last), 32'(beat == ROWS - 1));
            chk({v.name, " rread_send"}, 32'(rread), 32'd0);
            if (m_ready) beat++;
            cyc++;
            @(negedge clk);
        end
        chk({v.name, " beats_done"}, 32'(beat), 32'(ROWS));
        m_ready   = 1'b0;
        rvalid_in = '0;
        chk({v.name, " rread_ack"}, 32'(rread), 32'd1);
        chk({v.name, " m_valid_ack"}, 32'(m_valid), 32'd0);
        @(negedge clk);
        chk({v.name, " rread_rel"}, 32'(rread), 32'd0);
        chk({v.name, " tile_cnt"}, 32'(tile_cnt), 32'(v.exp_cnt));
        chk({v.name, " busy_rel"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({v.name, " busy_idle"}, 32'(busy), 32'd0);
        chk({v.name, " m_valid_idle"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;

        // Tile table: values, expected beats, ready pattern, expected counter after the tile.
        for (int i = 0; i < ROWS; i++) begin
            tbl[0].vals[i] = 32'(i + 100);
            tbl[1].vals[i] = 32'(i + 100);
            tbl[2].vals[i] = 32'(i * 7 + 3);
            tbl[3].vals[i] = 32'(i + 1);
            tbl[4].vals[i] = 32'(32'h1000 + i);
        end
        tbl[3].vals[2] = 32'hFFFF_FFFB;
        tbl[3].vals[5] = 32'h8000_0000;
        for (int t = 0; t < 5; t++) tbl[t].expv = tbl[t].vals;
`ifdef SA_DRAIN_RELU_EN
        tbl[3].expv[2] = 32'h0;
        tbl[3].expv[5] = 32'h0;
`endif
        tbl[0].name = "full_rate";  tbl[0].rpat = 16'hFFFF; tbl[0].exp_cnt = 2'd1; tbl[0].change_mid = 1'b0;
        tbl[1].name = "backpress";  tbl[1].rpat = 16'h9999; tbl[1].exp_cnt = 2'd2; tbl[1].change_mid = 1'b0;
        tbl[2].name = "snapshot";   tbl[2].rpat = 16'hFFFF; tbl[2].exp_cnt = 2'd3; tbl[2].change_mid = 1'b1;
        tbl[3].name = "relu_wrap";  tbl[3].rpat = 16'hB5AD; tbl[3].exp_cnt = 2'd0; tbl[3].change_mid = 1'b0;
        tbl[4].name = "after_wrap"; tbl[4].rpat = 16'hFFFF; tbl[4].exp_cnt = 2'd1; tbl[4].change_mid = 1'b0;

        // Reset held two cycles with all valids high.
        rstn      = 1'b0;
        rvalid_in = '1;
        m_ready   = 1'b1;
        for (int i = 0; i < ROWS; i++) r_in[i] = 32'(i + 100);
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst m_valid", 32'(m_valid), 32'd0);
            chk("rst rread", 32'(rread), 32'd0);
            chk("rst tile_cnt", 32'(tile_cnt), 32'd0);
            chk("rst busy", 32'(busy), 32'd0);
            chk("rst m_data", m_data, 32'd0);
            chk("rst m_last", 32'(m_last), 32'd0);
        end

        // Partial valids must never start a drain.
        rstn      = 1'b1;
        rvalid_in = 8'hFE;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("partial m_valid", 32'(m_valid), 32'd0);
            chk("partial busy", 32'(busy), 32'd0);
        end

        for (int t = 0; t < 5; t++) run_tile(tbl[t]);

        // Reset during beat 3 aborts the tile with no rread.
        r_in      = tbl[0].vals;
        rvalid_in = '1;
        m_ready   = 1'b1;
        @(negedge clk);
        rvalid_in = '0;
        for (int b = 0; b < 3; b++) begin
            chk("midrst beat", m_data, tbl[0].vals[b]);
            @(negedge clk);
        end
        chk("midrst beat3", m_data, tbl[0].vals[3]);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst m_valid", 32'(m_valid), 32'd0);
        chk("midrst rread", 32'(rread), 32'd0);
        chk("midrst tile_cnt", 32'(tile_cnt), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("midrst no_rread", 32'(rread), 32'd0);
            chk("midrst idle_valid", 32'(m_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
